ram_arbiter: RTL

Sequencer and two-port arbiter for the external 16-bit asynchronous SRAM. It shares one SRAM between the CPU instruction-fetch port and the data-memory port, and generates multi-cycle read and write strobe sequences from a single clock. Every access is a level-request / single-cycle-ack transaction. The block sits between the pipeline memory stages and the board SRAM pins.

---
 rtl/ram_pkg.sv | 38 +++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the external SRAM sequencer/arbiter:
//   - state_t     : sequencer states (IDLE, read, write setup/pulse/hold)
//   - ADDR_W_DEF  : default SRAM word-address width
//   - DATA_W_DEF  : default SRAM data width
//   - STROBE_OFF / STROBE_ON : levels of the active-low SRAM strobes
//   - cnt_t / phaseLoad : phase down-counter type and its load value
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  // Wide enough for any phase length the parameters can reasonably take.
  localparam int CNT_W = 8;

  // SRAM strobes are active-low.
  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR_S = 3'd2,
    S_WR_P = 3'd3,
    S_WR_H = 3'd4
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // A phase of N cycles is timed by loading N-1 and leaving when the
  // counter reaches zero.
  function automatic cnt_t phaseLoad(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares one external asynchronous 16-bit SRAM between the instruction-fetch
// port (read only) and the data-memory port (read/write). Each access is a
// level request answered by a single-cycle ack; the block generates the
// multi-cycle OE/WE strobe sequences from the system clock.
//
// Ports:
//   clk                 system clock, all state changes on posedge
//   rst                 synchronous, active-low reset
//   if_req/if_addr      fetch read request (level) and address
//   if_rdata/if_ack     fetch read data, valid during the one-cycle ack
//   mem_req/mem_we      data-port request (level), 1 = write
//   mem_addr/mem_wdata  data-port address and write data
//   mem_rdata/mem_ack   data-port read data, valid during the one-cycle ack
//   busy                high whenever the sequencer is not idle
//   RamAddr             SRAM address, held for the whole access
//   RamData             SRAM data bus, driven only while writing
//   RamOE/RamWE/RamEN   SRAM strobes, active-low
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 1,
  parameter int WR_HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] RamAddr,
  inout  wire  [DATA_W-1:0] RamData,
  output logic              RamOE,
  output logic              RamWE,
  output logic              RamEN
);

  state_t            state;
  cnt_t              cnt;
  logic              grantMem;   // port owning the current access (1 = mem)
  logic              favorMem;   // winner of the next contended arbitration
  logic              drvEn;      // RamData driven from wdataReg
  logic [DATA_W-1:0] wdataReg;

  logic ifElig;
  logic memElig;
  logic pickMem;

  // A port whose ack is high is still showing the request that was just
  // served, so it must not be granted again in that cycle.
  assign ifElig  = if_req  && !if_ack;
  assign memElig = mem_req && !mem_ack;
  assign pickMem = memElig && (!ifElig || favorMem);

  assign busy    = (state != S_IDLE);
  assign RamData = drvEn ? wdataReg : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grantMem  <= 1'b0;
      favorMem  <= 1'b1;
      drvEn     <= 1'b0;
      wdataReg  <= '0;
      RamAddr   <= '0;
      RamOE     <= STROBE_OFF;
      RamWE     <= STROBE_OFF;
      RamEN     <= STROBE_OFF;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        // IDLE: arbitrate and launch the access
        S_IDLE: begin
          if (ifElig || memElig) begin
            grantMem <= pickMem;
            // Fairness only moves when both ports actually competed.
            if (ifElig && memElig) favorMem <= ~pickMem;
            RamAddr <= pickMem ? mem_addr : if_addr;
            RamEN   <= STROBE_ON;
            if (pickMem && mem_we) begin
              wdataReg <= mem_wdata;
              drvEn    <= 1'b1;
              cnt      <= phaseLoad(WR_SETUP);
              state    <= S_WR_S;
            end else begin
              RamOE <= STROBE_ON;
              cnt   <= phaseLoad(RD_WAIT);
              state <= S_RD;
            end
          end
        end

        // RD: OE held low, data captured on the last cycle
        S_RD: begin
          if (cnt == '0) begin
            if (grantMem) begin
              mem_rdata <= RamData;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= RamData;
              if_ack   <= 1'b1;
            end
            RamOE <= STROBE_OFF;
            RamEN <= STROBE_OFF;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        // WR_S: address and data settle with WE still high
        S_WR_S: begin
          if (cnt == '0) begin
            RamWE <= STROBE_ON;
            cnt   <= phaseLoad(WR_PULSE);
            state <= S_WR_P;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        // WR_P: write pulse
        S_WR_P: begin
          if (cnt == '0) begin
            RamWE <= STROBE_OFF;
            cnt   <= phaseLoad(WR_HOLD);
            state <= S_WR_H;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        // WR_H: data held after WE rises, then the bus is released
        S_WR_H: begin
          if (cnt == '0) begin
            drvEn   <= 1'b0;
            RamEN   <= STROBE_OFF;
            mem_ack <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt - cnt_t'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
